alarm_sched: RTL
================

ALARM_SCHED -- requirements
Module: alarm_sched

Interface
REQ-001 Parameter RING_SEC, default 60: ring duration in 1 Hz ticks; legal range 1..511.
REQ-002 Parameter SNOOZE_SEC, default 300: snooze duration in 1 Hz ticks; legal range 1..511.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event; legal range 0..3.
REQ-004 clk  input  1  system clock (50 MHz).
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 i_tick_1hz  input  1  single-cycle strobe, synchronous to clk, once per second.
REQ-007 i_match  input  1  level; high while current time equals alarm time.
REQ-008 i_alarm_en  input  1  level; alarm armed.
REQ-009 i_snooze  input  1  single-cycle pulse from the debounced snooze button.
REQ-010 i_stop  input  1  single-cycle pulse from the debounced stop button.
REQ-011 o_buzz_en  output  1  buzzer enable; drives the buzz block enable.
REQ-012 o_state  output  2  FSM state: 00 IDLE, 01 RING, 10 SNOOZE.
REQ-013 o_snooze_cnt  output  2  snoozes used in the current event.
REQ-014 o_remain  output  9  seconds remaining in RING or SNOOZE; 0 in IDLE.
REQ-015 o_blink  output  1  display decimal-point blink.
REQ-016 o_missed  output  1  sticky flag: ring timed out without user action.

Function
REQ-017 All outputs SHALL be registered on posedge clk.
REQ-018 Match detect: a rising edge of i_match SHALL be detected using a 1-cycle delayed copy of i_match; a level held high SHALL NOT retrigger.
REQ-019 Per-cycle event priority: i_alarm_en=0, then i_stop, then i_snooze, then tick expiry, then match edge.
REQ-020 In any state, i_alarm_en=0 SHALL force IDLE on the next edge and clear the timer, o_snooze_cnt and o_blink; o_missed is held.
REQ-021 IDLE, on match edge with i_alarm_en=1: next state RING; o_remain=RING_SEC; o_snooze_cnt=0; o_missed=0.
REQ-022 RING: o_buzz_en=1 in the same cycle that o_state=01; o_buzz_en=0 in all other states.
REQ-023 RING with i_stop: next state IDLE; o_remain=0.
REQ-024 RING with i_snooze and o_snooze_cnt<MAX_SNOOZE: next state SNOOZE; o_remain=SNOOZE_SEC; o_snooze_cnt incremented by 1.
REQ-025 RING with i_snooze and o_snooze_cnt=MAX_SNOOZE: the pulse SHALL be ignored (no state change).
REQ-026 RING/SNOOZE on tick with o_remain>1: o_remain decrements by 1.
REQ-027 RING on tick with o_remain=1: next state IDLE; o_remain=0; o_missed=1.
REQ-028 SNOOZE on tick with o_remain=1: next state RING; o_remain=RING_SEC.
REQ-029 SNOOZE with i_stop: next state IDLE; i_snooze in SNOOZE SHALL be ignored.
REQ-030 A match edge in RING or SNOOZE SHALL be ignored.
REQ-031 A tick in the same cycle as a stop or an accepted snooze SHALL NOT decrement the newly loaded timer.
REQ-032 o_blink SHALL toggle on each tick in RING and be 0 in IDLE and SNOOZE.
REQ-033 o_missed SHALL clear on i_stop in any state, or on a new RING entry from IDLE.
REQ-034 Timer arithmetic is 9-bit unsigned; o_remain SHALL never wrap below 0.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state IDLE; o_buzz_en=0; o_snooze_cnt=0; o_remain=0; o_blink=0; o_missed=0; match-delay register=0.
REQ-036 Reset asserted mid-RING or mid-SNOOZE SHALL abort the event; after release, a match level still high SHALL NOT trigger RING until i_match falls and rises again.

Verification (bench parameters: RING_SEC=3, SNOOZE_SEC=5, MAX_SNOOZE=2)
REQ-037 i_alarm_en=1, i_match rises -> next edge o_state=01, o_buzz_en=1, o_remain=3; 3 ticks later -> o_state=00, o_missed=1.
REQ-038 In RING, snooze pulse -> o_state=10, o_remain=5, o_snooze_cnt=1, o_buzz_en=0; after 5 ticks -> o_state=01, o_remain=3.
REQ-039 Two snoozes accepted, third snooze while ringing -> state stays 01, o_snooze_cnt=2; stop pulse -> o_state=00, o_missed=0.
REQ-040 i_match held high for 10 ticks, then stop in the first cycle of RING -> IDLE with no retrigger while i_match stays high.
REQ-041 Snooze and tick in the same cycle in RING (o_remain=1) -> SNOOZE, o_remain=5; stop and snooze in the same cycle -> IDLE.
REQ-042 i_alarm_en dropped mid-SNOOZE -> IDLE next edge, o_remain=0; rst_n pulsed mid-RING -> all outputs 0 immediately.

Source files
------------

// File: rtl/alarm_sched.sv
// Alarm event scheduler: detects the alarm-time match, runs the ring/snooze
// timers from the 1 Hz strobe, and reports buzzer, blink and missed status.
// Every output comes straight from a flop.
module alarm_sched #(
  parameter int unsigned RING_SEC   = 60,   // 1..511
  parameter int unsigned SNOOZE_SEC = 300,  // 1..511
  parameter int unsigned MAX_SNOOZE = 3     // 0..3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_match,
  input  logic       i_alarm_en,
  input  logic       i_snooze,
  input  logic       i_stop,
  output logic       o_buzz_en,
  output logic [1:0] o_state,
  output logic [1:0] o_snooze_cnt,
  output logic [8:0] o_remain,
  output logic       o_blink,
  output logic       o_missed
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRing   = 2'b01,
    StSnooze = 2'b10
  } state_e;

  localparam logic [8:0] RingLoad   = 9'(RING_SEC);
  localparam logic [8:0] SnoozeLoad = 9'(SNOOZE_SEC);
  localparam logic [1:0] MaxSnooze  = 2'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [8:0] remain_q, remain_d;
  logic [1:0] cnt_q, cnt_d;
  logic       blink_q, blink_d;
  logic       missed_q, missed_d;
  logic       buzz_q, buzz_d;
  logic       match_q;
  // Cleared by reset; set once i_match has been seen low. A match level that
  // survives a reset therefore cannot pose as a fresh rising edge.
  logic       match_ok_q, match_ok_d;

  logic       match_edge;
  logic       snooze_ok;
  logic       timer_last;

  assign match_edge = i_match & ~match_q & match_ok_q;
  assign snooze_ok  = i_snooze && (state_q == StRing) && (cnt_q < MaxSnooze);
  // Treat 0 like 1 so the timer can never wrap, even from an illegal value.
  assign timer_last = (remain_q <= 9'd1);
  assign match_ok_d = match_ok_q | ~i_match;

  // Next-state decode, highest-priority event first; one event wins per cycle.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    missed_d = missed_q;

    if (!i_alarm_en) begin
      // Disarm: abort the event but keep the missed indication visible.
      state_d  = StIdle;
      remain_d = 9'd0;
      cnt_d    = 2'd0;
      blink_d  = 1'b0;
    end else if (i_stop) begin
      state_d  = StIdle;
      remain_d = 9'd0;
      blink_d  = 1'b0;
      missed_d = 1'b0;
    end else if (snooze_ok) begin
      state_d  = StSnooze;
      remain_d = SnoozeLoad;
      cnt_d    = cnt_q + 2'd1;
      blink_d  = 1'b0;
    end else if (i_tick_1hz && (state_q != StIdle)) begin
      if (!timer_last) begin
        remain_d = remain_q - 9'd1;
        if (state_q == StRing) begin
          blink_d = ~blink_q;
        end
      end else if (state_q == StRing) begin
        // Rang out with nobody touching a button.
        state_d  = StIdle;
        remain_d = 9'd0;
        blink_d  = 1'b0;
        missed_d = 1'b1;
      end else begin
        state_d  = StRing;
        remain_d = RingLoad;
        blink_d  = 1'b0;
      end
    end else if (match_edge && (state_q == StIdle)) begin
      state_d  = StRing;
      remain_d = RingLoad;
      cnt_d    = 2'd0;
      blink_d  = 1'b0;
      missed_d = 1'b0;
    end
  end

  // Buzzer follows the next state so it changes on the same edge as o_state.
  always_comb begin
    buzz_d = (state_d == StRing);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      remain_q   <= 9'd0;
      cnt_q      <= 2'd0;
      blink_q    <= 1'b0;
      missed_q   <= 1'b0;
      buzz_q     <= 1'b0;
      match_q    <= 1'b0;
      match_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      missed_q   <= missed_d;
      buzz_q     <= buzz_d;
      match_q    <= i_match;
      match_ok_q <= match_ok_d;
    end
  end

  assign o_buzz_en    = buzz_q;
  assign o_state      = state_q;
  assign o_snooze_cnt = cnt_q;
  assign o_remain     = remain_q;
  assign o_blink      = blink_q;
  assign o_missed     = missed_q;

endmodule
